// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - ALU opcode constants (the select codes driven on alu_s)
//   - FSM state encoding for alu_op_sequencer
//   - sel_flag(): masks the ALU carry/borrow so that only add/sub report it
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // The ALU leaves carry/borrow undriven (X) for compare and and.
    // The selection is made on the opcode alone, so an X on cb can
    // never reach the result for those opcodes.
    function automatic logic sel_flag(input logic [1:0] op, input logic cb);
        return (op == OP_ADD || op == OP_SUB) ? cb : 1'b0;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to a combinational 4-bit
// style ALU, holds the operands for SETTLE cycles, captures the result and
// returns it on a response handshake.
//
// Parameters:
//   WIDTH  - operand/result width (>= 3)
//   SETTLE - cycles operands are held before the result is sampled (>= 1)
//   CNT_W  - width of the wrapping completed-operation counter
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_a, cmd_b            opcode and operands
//   cmd_chain                       (ALU_SEQ_CHAIN_EN only) take A from last result
//   alu_s, alu_a, alu_b             registered ALU select and operands
//   alu_result, alu_cb, alu_cmp     ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_op, rsp_data, rsp_flag      response opcode, data and carry/borrow
//   busy                            sequencer not idle
//   op_count                        completed responses (wraps)
//
// Optional feature macro: ALU_SEQ_CHAIN_EN adds cmd_chain; when set on
// acceptance, alu_a is loaded from the last completed rsp_data.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [1:0]        alu_s,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_cb,
    input  logic [2:0]        alu_cmp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_flag,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE - 1);

    generate
        if (WIDTH < 3) begin : g_bad_width
            $error("alu_op_sequencer: WIDTH must be >= 3");
        end
        if (SETTLE < 1) begin : g_bad_settle
            $error("alu_op_sequencer: SETTLE must be >= 1");
        end
    endgenerate

    logic [1:0]        state;
    logic [SCNT_W-1:0] settle_cnt;
    logic [WIDTH-1:0]  a_next;
    logic [WIDTH-1:0]  cap_data;
    logic              accept;
    logic              sample;
    logic              handshake;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign sample    = (state == ST_DRIVE) && (settle_cnt == '0);
    assign handshake = (state == ST_RESP) && rsp_ready;

    // rsp_data only changes on a capture and is not cleared after the
    // handshake, so in IDLE it is exactly the last completed result.
    always_comb begin
`ifdef ALU_SEQ_CHAIN_EN
        a_next = cmd_chain ? rsp_data : cmd_a;
`else
        a_next = cmd_a;
`endif
    end

    // Compare returns the 3-bit vector zero-extended; everything else
    // returns the ALU result bus.
    always_comb begin
        cap_data = alu_result;
        if (alu_s == OP_CMP) begin
            cap_data = WIDTH'(alu_cmp);
        end
    end

    // Control: FSM, settle counter, response valid, completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            rsp_valid  <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (sample) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - SCNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (handshake) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: ALU drive registers change only on acceptance; response
    // registers change only on the sampling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_op   <= '0;
            rsp_data <= '0;
            rsp_flag <= 1'b0;
        end else begin
            if (accept) begin
                alu_s  <= cmd_op;
                alu_a  <= a_next;
                alu_b  <= cmd_b;
                rsp_op <= cmd_op;
            end
            if (sample) begin
                rsp_data <= cap_data;
                rsp_flag <= sel_flag(alu_s, alu_cb);
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer.
// Two instances: dut (SETTLE=1) and dut3 (SETTLE=3), each driving its own
// combinational ALU model. Define ALU_SEQ_CHAIN_EN to also exercise the
// operand-chaining feature.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    logic       cmd_chain;
`endif

    // SETTLE=1 instance
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_flag, busy, alu_cb;
    logic [1:0] alu_s, rsp_op;
    logic [3:0] alu_a, alu_b, alu_result, rsp_data;
    logic [2:0] alu_cmp;
    logic [7:0] op_count;

    // SETTLE=3 instance
    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_flag3, busy3, alu_cb3;
    logic [1:0] alu_s3, rsp_op3;
    logic [3:0] alu_a3, alu_b3, alu_result3, rsp_data3;
    logic [2:0] alu_cmp3;
    logic [7:0] op_count3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] d;
        logic       f;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       f;
    } vec_t;
    vec_t vt[9];

    alu_op_sequencer #(.WIDTH(4), .SETTLE(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_cb(alu_cb), .alu_cmp(alu_cmp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .busy(busy), .op_count(op_count)
    );

    alu_op_sequencer #(.WIDTH(4), .SETTLE(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_s(alu_s3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3), .alu_cb(alu_cb3), .alu_cmp(alu_cmp3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_op(rsp_op3), .rsp_data(rsp_data3), .rsp_flag(rsp_flag3),
        .busy(busy3), .op_count(op_count3)
    );

    // Combinational ALU: {cmp[2:0], cb, result[3:0]}; cmp = {gt, eq, lt}.
    // cb is undriven (X) for compare and and.
    function automatic logic [7:0] alu_fn(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        logic [2:0] c;
        c = {a > b, a == b, a < b};
        case (s)
            2'b00: begin t = {1'b0, a} + {1'b0, b}; return {c, t}; end
            2'b01: begin t = {1'b0, a} - {1'b0, b}; return {c, t}; end
            2'b10: return {c, 1'bx, 4'h0};
            default: return {c, 1'bx, a & b};
        endcase
    endfunction

    assign {alu_cmp, alu_cb, alu_result}    = alu_fn(alu_s, alu_a, alu_b);
    assign {alu_cmp3, alu_cb3, alu_result3} = alu_fn(alu_s3, alu_a3, alu_b3);

    // Expected response for random traffic, written arithmetically.
    function automatic void ref_rsp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] d, output logic f);
        int sa;
        int sb_;
        sa  = int'(a);
        sb_ = int'(b);
        f = 1'b0;
        case (op)
            2'b00: begin d = 4'((sa + sb_) % 16); f = (sa + sb_) > 15; end
            2'b01: begin d = 4'((sa - sb_ + 16) % 16); f = sa < sb_; end
            2'b10: d = (sa > sb_) ? 4'd4 : ((sa == sb_) ? 4'd2 : 4'd1);
            default: d = a & b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response handshake of dut pops one expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_op", rsp_op, e.op);
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_flag", rsp_flag, e.f);
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ea, input logic [3:0] ed, input logic ef, input int stall);
        int n;
        logic [7:0] exp_cnt;
        exp_t e;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            cmd_valid = 1'b0;
            return;
        end
        exp_cnt = op_count + 8'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e.op = op; e.d = ed; e.f = ef;
        sb.push_back(e);
        chk("alu_s", alu_s, op);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, b);
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("rsp_latency", n, 1);
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data", rsp_data, ed);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("op_count_inc", op_count, exp_cnt);
    endtask

    initial begin
        int n;
        int errs;
        int guard;
        logic [7:0] cnt0;
        logic [7:0] cnt1;
        logic [1:0] rop;
        logic [3:0] ra, rb, rd;
        logic       rf;
        exp_t e;

        vt[0] = '{2'b00, 4'h9, 4'h8, 4'h1, 1'b1};
        vt[1] = '{2'b01, 4'h3, 4'h5, 4'hE, 1'b1};
        vt[2] = '{2'b10, 4'h7, 4'h7, 4'h2, 1'b0};
        vt[3] = '{2'b11, 4'hC, 4'hA, 4'h8, 1'b0};
        vt[4] = '{2'b00, 4'h3, 4'h4, 4'h7, 1'b0};
        vt[5] = '{2'b01, 4'h9, 4'h2, 4'h7, 1'b0};
        vt[6] = '{2'b10, 4'h2, 4'h9, 4'h1, 1'b0};
        vt[7] = '{2'b10, 4'h9, 4'h2, 4'h4, 1'b0};
        vt[8] = '{2'b11, 4'hF, 4'hF, 4'hF, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_valid3 = 1'b0; rsp_ready3 = 1'b0;
        cmd_op = 2'b00; cmd_a = 4'h0; cmd_b = 4'h0;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        #2;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu", {alu_s, alu_a, alu_b}, 10'd0);
        chk("rst_rsp", {rsp_op, rsp_data, rsp_flag}, 7'd0);
        chk("rst_op_count", op_count, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_cmd(vt[i].op, vt[i].a, vt[i].b, vt[i].a, vt[i].d, vt[i].f, i % 3);
        end

        // Back-pressure with a second command waiting
        cmd_op = 2'b00; cmd_a = 4'h1; cmd_b = 4'h2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        e.op = 2'b00; e.d = 4'h3; e.f = 1'b0; sb.push_back(e);
        cmd_op = 2'b01; cmd_a = 4'h6; cmd_b = 4'h1;
        @(posedge clk); #1;
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        cnt0 = op_count;
        cnt1 = cnt0 + 8'd1;
        errs = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 4'h3 || rsp_op !== 2'b00 ||
                cmd_ready !== 1'b0 || op_count !== cnt0 || alu_a !== 4'h1) errs++;
        end
        chk("bp_hold_errors", errs, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_count", op_count, cnt1);
        chk("bp_not_taken_yet", alu_a, 4'h1);
        chk("bp_idle_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e.op = 2'b01; e.d = 4'h5; e.f = 1'b0; sb.push_back(e);
        chk("bp_second_taken", {alu_s, alu_a, alu_b}, {2'b01, 4'h6, 4'h1});
        chk("bp_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("bp_second_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // SETTLE=3 instance
        chk("s3_ready", cmd_ready3, 1'b1);
        cmd_op = 2'b01; cmd_a = 4'h3; cmd_b = 4'h5; cmd_valid3 = 1'b1;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        chk("s3_alu", {alu_s3, alu_a3, alu_b3}, {2'b01, 4'h3, 4'h5});
        n = 0; errs = 0;
        while (!rsp_valid3 && n < 20) begin
            @(posedge clk); #1; n++;
            if (alu_s3 !== 2'b01 || alu_a3 !== 4'h3 || alu_b3 !== 4'h5) errs++;
        end
        chk("s3_latency", n, 3);
        chk("s3_alu_stable", errs, 0);
        chk("s3_rsp", {rsp_op3, rsp_data3, rsp_flag3}, {2'b01, 4'hE, 1'b1});
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        chk("s3_count", op_count3, 8'd1);
        chk("s3_drop", rsp_valid3, 1'b0);

        // Reset while in DRIVE
        cmd_op = 2'b00; cmd_a = 4'h9; cmd_b = 4'h8; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_alu", {alu_s, alu_a, alu_b}, 10'd0);
        chk("mid_rst_rsp", {rsp_valid, rsp_op, rsp_data, rsp_flag}, 8'd0);
        chk("mid_rst_count", op_count, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        errs = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) errs++;
        end
        chk("post_rst_quiet", errs, 0);
        chk("post_rst_count", op_count, 8'd0);

        // Counter wrap with random traffic
        guard = 0;
        while (op_count != 8'hFF && guard < 300) begin
            rop = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ref_rsp(rop, ra, rb, rd, rf);
            do_cmd(rop, ra, rb, ra, rd, rf, 0);
            guard++;
        end
        chk("wrap_reach", op_count, 8'hFF);
        do_cmd(2'b00, 4'hF, 4'h1, 4'hF, 4'h0, 1'b1, 0);
        chk("wrap_zero", op_count, 8'd0);

`ifdef ALU_SEQ_CHAIN_EN
        do_cmd(2'b00, 4'h2, 4'h3, 4'h2, 4'h5, 1'b0, 0);
        cmd_chain = 1'b1;
        do_cmd(2'b11, 4'hF, 4'h6, 4'h5, 4'h4, 1'b0, 0);
        cmd_chain = 1'b0;
`endif

        @(posedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequential command issuer that drives the 4-bit ALU's select and operand inputs and collects its result.
- Accepts one command (opcode plus operands) per valid/ready handshake.
- Drives opcode and operands as registered outputs to the ALU and holds them stable for SETTLE cycles.
- Samples the ALU result and flags, then returns a response on a second valid/ready handshake.
- Sits between a controller or bus slave and the ALU; it is the initiator side of the ALU's S/A/B/result interface.

Parameters:
WIDTH, 4, operand/result width; must be >= 3.
SETTLE, 1, cycles operands are held before the result is sampled; must be >= 1 (elaboration error otherwise).
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
cmd_op  in  2  00 add, 01 sub, 10 compare, 11 and
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
alu_s  out  2  ALU select (registered)
alu_a  out  WIDTH  ALU operand A (registered)
alu_b  out  WIDTH  ALU operand B (registered)
alu_result  in  WIDTH  ALU add/sub/and result
alu_cb  in  1  ALU carry/borrow
alu_cmp  in  3  ALU compare vector
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when high together with rsp_valid
rsp_op  out  2  opcode of this response
rsp_data  out  WIDTH  result
rsp_flag  out  1  carry (add), borrow (sub), 0 otherwise
busy  out  1  state != IDLE
op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except cmd_ready=1; state=IDLE; settle counter 0.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, at that edge: load alu_s/alu_a/alu_b from cmd_op/cmd_a/cmd_b, latch rsp_op, load settle counter with SETTLE-1, go to DRIVE.
  - DRIVE: cmd_ready=0; alu_* held. Counter decrements each edge. On the edge where the counter is 0:
    - sample rsp_data and rsp_flag;
    - set rsp_valid=1;
    - go to RESP.
  - RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0. On handshake: rsp_valid=0, op_count+1, go to IDLE.
- Latency and throughput: rsp_valid rises exactly SETTLE edges after the accepting edge. Minimum spacing between accepted commands is SETTLE+2 cycles; no overlap or pipelining.
- Result mapping:
  - add/sub/and: rsp_data = alu_result.
  - compare: rsp_data = zero-extended alu_cmp.
  - rsp_flag = alu_cb for op 00/01 only; forced 0 for 10/11, since the ALU drives X there and X must never propagate.
- Holding: alu_* keep their last driven values after completion (not cleared); they change only on command acceptance.
- cmd_valid in DRIVE or RESP: ignored; the command is not consumed.
- op_count: wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: the in-flight command is discarded, no response is ever produced for it, and all outputs return to reset values immediately.
- Simultaneous rsp handshake and cmd_valid: the new command is not accepted in that cycle; it is accepted in the following IDLE cycle.

Optional Feature:
ALU_SEQ_CHAIN_EN:
- Defined:
  - adds input port cmd_chain (1 bit);
  - on acceptance with cmd_chain=1, alu_a is loaded from the last completed rsp_data instead of cmd_a;
  - last rsp_data resets to 0.
- Undefined: port absent; alu_a always from cmd_a.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_AND=2'b11;
  - FSM state encoding (IDLE, DRIVE, RESP);
  - function sel_flag(op, cb) that returns the masked flag.
- No sub-module: FSM, settle counter and capture registers stay in one module.

Test Plan:
The bench models the ALU combinationally. SETTLE=1 unless noted.
1. ADD a=4'h9 b=4'h8 -> alu_s=00, alu_a=9, alu_b=8 after the accept edge; rsp_valid one edge later; rsp_data=4'h1, rsp_flag=1, rsp_op=00.
2. SUB a=3 b=5 with the model giving borrow=1 -> rsp_data=4'hE, rsp_flag=1. Repeat with SETTLE=3: rsp_valid 3 edges after accept; alu_* stable throughout.
3. CMP a=7 b=7 with model alu_cb=X -> rsp_data={0,alu_cmp}, rsp_flag=0 (never X). AND a=4'hC b=4'hA -> rsp_data=4'h8, flag=0.
4. Hold rsp_ready=0 for 5 cycles with a second cmd_valid pending:
   - rsp_* stable and cmd_ready=0 throughout;
   - second command accepted the cycle after the rsp handshake;
   - op_count increments only on handshakes;
   - with CNT_W=8, 256 ops wrap op_count to 0.
5. Assert rst_n low in DRIVE -> all outputs at reset values asynchronously; after release no rsp_valid appears; op_count=0.
6. With ALU_SEQ_CHAIN_EN: ADD 2+3 (rsp 5), then AND with cmd_chain=1, cmd_a=F, b=6 -> alu_a=5, rsp_data=4'h4.
